// File: rtl/fir_xifu_offload_pkg.sv
// Shared types for the FIR XIF offload initiator (issue FSM state, latched instruction).
package fir_xifu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2
    } fir_xifu_offload_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } fir_xifu_offload_instr_t;

endpackage

// File: rtl/fir_xifu_offload_if.sv
// Reduced CV32E40X eXtension interface: the issue, commit, memory, memory-result and result
// channels, with the CPU-side modports used by the offload initiator.
interface cv32e40x_if_xif #(
    parameter int X_ID_WIDTH = 4
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [31:0]           issue_instr;
    logic [1:0][31:0]      issue_rs;
    logic [1:0]            issue_rs_valid;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic                  issue_accept;

    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [X_ID_WIDTH-1:0] mem_id;
    logic [31:0]           mem_addr;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_exc;

    logic                  mem_result_valid;
    logic [X_ID_WIDTH-1:0] mem_result_id;
    logic [31:0]           mem_result_rdata;
    logic                  mem_result_err;

    logic                  result_valid;
    logic                  result_ready;
    logic [31:0]           result_data;
    logic [4:0]            result_rd;
    logic                  result_we;

    modport cpu_issue (
        output issue_valid, issue_instr, issue_rs, issue_rs_valid, issue_id,
        input  issue_ready, issue_accept
    );
    modport cpu_commit (output commit_valid, commit_id, commit_kill);
    modport cpu_mem (
        input  mem_valid, mem_id, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_ready, mem_exc
    );
    modport cpu_mem_result (output mem_result_valid, mem_result_id, mem_result_rdata, mem_result_err);
    modport cpu_result (
        input  result_valid, result_data, result_rd, result_we,
        output result_ready
    );
endinterface

// File: rtl/fir_xifu_offload_mem.sv
// Bridges XIF memory requests onto a plain req/gnt/rvalid data port, one transaction in flight.
module fir_xifu_offload_mem #(
    parameter int X_ID_WIDTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    cv32e40x_if_xif.cpu_mem               xif_mem,
    cv32e40x_if_xif.cpu_mem_result        xif_mem_result,
    output logic                          data_req_o,
    output logic                          data_we_o,
    output logic [31:0]                   data_addr_o,
    output logic [3:0]                    data_be_o,
    output logic [31:0]                   data_wdata_o,
    input  logic                          data_gnt_i,
    input  logic                          data_rvalid_i,
    input  logic [31:0]                   data_rdata_i
);
    logic                  pending_q;
    logic [X_ID_WIDTH-1:0] id_q;

    assign data_req_o   = xif_mem.mem_valid & ~pending_q & ~rst_i;
    assign data_we_o    = xif_mem.mem_we;
    assign data_addr_o  = xif_mem.mem_addr;
    assign data_be_o    = xif_mem.mem_be;
    assign data_wdata_o = xif_mem.mem_wdata;

    assign xif_mem.mem_ready = data_gnt_i & ~pending_q & ~rst_i;
    assign xif_mem.mem_exc   = 1'b0;

    // Gating with pending_q drops any response left over from before a reset.
    assign xif_mem_result.mem_result_valid = data_rvalid_i & pending_q;
    assign xif_mem_result.mem_result_id    = id_q;
    assign xif_mem_result.mem_result_rdata = data_rdata_i;
    assign xif_mem_result.mem_result_err   = 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            id_q      <= '0;
        end else if (xif_mem.mem_valid && xif_mem.mem_ready) begin
            pending_q <= 1'b1;
            id_q      <= xif_mem.mem_id;
        end else if (data_rvalid_i && pending_q) begin
            pending_q <= 1'b0;
        end
    end
endmodule

// File: rtl/fir_xifu_offload.sv
// Core-side XIF initiator standing in for CV32E40X: issues, commits, bridges memory, retires results.
// Optional kill input enabled by defining FIR_XIFU_OFFLOAD_KILL_EN.
module fir_xifu_offload
    import fir_xifu_pkg::*;
#(
    parameter int NB_OUTSTANDING = 4,
    parameter int X_ID_WIDTH     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
`ifdef FIR_XIFU_OFFLOAD_KILL_EN
    input  logic                   kill_i,
`endif
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic [31:0]            instr_i,
    input  logic [31:0]            rs1_i,
    input  logic [31:0]            rs2_i,
    output logic                   illegal_o,
    cv32e40x_if_xif.cpu_issue      xif_issue_o,
    cv32e40x_if_xif.cpu_commit     xif_commit_o,
    cv32e40x_if_xif.cpu_mem        xif_mem_i,
    cv32e40x_if_xif.cpu_mem_result xif_mem_result_o,
    cv32e40x_if_xif.cpu_result     xif_result_i,
    output logic                   data_req_o,
    output logic                   data_we_o,
    output logic [31:0]            data_addr_o,
    output logic [3:0]             data_be_o,
    output logic [31:0]            data_wdata_o,
    input  logic                   data_gnt_i,
    input  logic                   data_rvalid_i,
    input  logic [31:0]            data_rdata_i,
    output logic                   rf_we_o,
    output logic [4:0]             rf_waddr_o,
    output logic [31:0]            rf_wdata_o
);
    localparam int               CNT_W   = $clog2(NB_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NB_OUTSTANDING);

    fir_xifu_offload_state_t state_q, state_d;
    fir_xifu_offload_instr_t instr_q;
    logic                    accept_q;
    logic [X_ID_WIDTH-1:0]   id_q, commit_id_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    instr_hs, issue_hs, kill_now;
    int                      cnt_sum;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d  = state_q;
        instr_hs = 1'b0;
        issue_hs = 1'b0;
        case (state_q)
            IDLE: if (instr_valid_i && instr_ready_o) begin
                instr_hs = 1'b1;
                state_d  = ISSUE;
            end
            ISSUE: if (xif_issue_o.issue_ready) begin
                issue_hs = 1'b1;
                state_d  = COMMIT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_ready_o = (state_q == IDLE) && (cnt_q < CNT_MAX) && !rst_i;
    assign illegal_o     = (state_q == COMMIT) && !accept_q;

    assign xif_issue_o.issue_valid    = (state_q == ISSUE);
    assign xif_issue_o.issue_instr    = instr_q.instr;
    assign xif_issue_o.issue_rs       = {instr_q.rs2, instr_q.rs1};
    assign xif_issue_o.issue_rs_valid = (state_q == ISSUE) ? 2'b11 : 2'b00;
    assign xif_issue_o.issue_id       = id_q;

    assign xif_commit_o.commit_valid = (state_q == COMMIT);
    assign xif_commit_o.commit_id    = commit_id_q;
    assign xif_commit_o.commit_kill  = (state_q == COMMIT) && (!accept_q || kill_now);

    assign xif_result_i.result_ready = 1'b1;

    // A killed but accepted instruction gives back the slot it took at issue.
    always_comb begin
        cnt_sum = int'(cnt_q);
        if (issue_hs && xif_issue_o.issue_accept) cnt_sum = cnt_sum + 1;
        if (xif_result_i.result_valid)            cnt_sum = cnt_sum - 1;
        if (state_q == COMMIT && accept_q && kill_now) cnt_sum = cnt_sum - 1;
        if (cnt_sum < 0)                   cnt_sum = 0;
        else if (cnt_sum > NB_OUTSTANDING) cnt_sum = NB_OUTSTANDING;
        cnt_d = CNT_W'(cnt_sum);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            accept_q    <= 1'b0;
            id_q        <= '0;
            commit_id_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (instr_hs) instr_q <= '{instr: instr_i, rs1: rs1_i, rs2: rs2_i};
            if (issue_hs) begin
                accept_q    <= xif_issue_o.issue_accept;
                commit_id_q <= id_q;
                id_q        <= id_q + X_ID_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            rf_we_o <= xif_result_i.result_valid && xif_result_i.result_we;
            if (xif_result_i.result_valid && xif_result_i.result_we) begin
                rf_waddr_o <= xif_result_i.result_rd;
                rf_wdata_o <= xif_result_i.result_data;
            end
        end
    end

`ifdef FIR_XIFU_OFFLOAD_KILL_EN
    logic kill_pending_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)                  kill_pending_q <= 1'b0;
        else if (kill_i)            kill_pending_q <= 1'b1;
        else if (state_q == COMMIT) kill_pending_q <= 1'b0;
    end
    assign kill_now = kill_pending_q;
`else
    assign kill_now = 1'b0;
`endif

    fir_xifu_offload_mem #(.X_ID_WIDTH(X_ID_WIDTH)) u_mem (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .xif_mem        (xif_mem_i),
        .xif_mem_result (xif_mem_result_o),
        .data_req_o     (data_req_o),
        .data_we_o      (data_we_o),
        .data_addr_o    (data_addr_o),
        .data_be_o      (data_be_o),
        .data_wdata_o   (data_wdata_o),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i)
    );
endmodule

// File: tb/tb_fir_xifu_offload.sv
// Directed bench for fir_xifu_offload; defining FIR_XIFU_OFFLOAD_KILL_EN also exercises kill_i.
module tb_fir_xifu_offload;
    logic        clk = 1'b0;
    logic        rst_i;
`ifdef FIR_XIFU_OFFLOAD_KILL_EN
    logic        kill_i;
`endif
    logic        instr_valid, instr_ready, illegal;
    logic [31:0] instr_w, rs1_w, rs2_w;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_vec = 0;
    int n_err = 0;

    cv32e40x_if_xif #(.X_ID_WIDTH(4)) xif ();

    fir_xifu_offload #(.NB_OUTSTANDING(4), .X_ID_WIDTH(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
`ifdef FIR_XIFU_OFFLOAD_KILL_EN
        .kill_i           (kill_i),
`endif
        .instr_valid_i    (instr_valid),
        .instr_ready_o    (instr_ready),
        .instr_i          (instr_w),
        .rs1_i            (rs1_w),
        .rs2_i            (rs2_w),
        .illegal_o        (illegal),
        .xif_issue_o      (xif),
        .xif_commit_o     (xif),
        .xif_mem_i        (xif),
        .xif_mem_result_o (xif),
        .xif_result_i     (xif),
        .data_req_o       (data_req),
        .data_we_o        (data_we),
        .data_addr_o      (data_addr),
        .data_be_o        (data_be),
        .data_wdata_o     (data_wdata),
        .data_gnt_i       (data_gnt),
        .data_rvalid_i    (data_rvalid),
        .data_rdata_i     (data_rdata),
        .rf_we_o          (rf_we),
        .rf_waddr_o       (rf_waddr),
        .rf_wdata_o       (rf_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_instr(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        instr_valid = 1'b1;
        instr_w     = w;
        rs1_w       = a;
        rs2_w       = b;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic issue_hs(input logic acc);
        xif.issue_ready  = 1'b1;
        xif.issue_accept = acc;
        tick();
        xif.issue_ready  = 1'b0;
        xif.issue_accept = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_id;
        rst_i = 1'b1;
`ifdef FIR_XIFU_OFFLOAD_KILL_EN
        kill_i = 1'b0;
`endif
        instr_valid = 1'b0; instr_w = '0; rs1_w = '0; rs2_w = '0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        xif.issue_ready = 1'b0; xif.issue_accept = 1'b0;
        xif.mem_valid = 1'b0; xif.mem_id = '0; xif.mem_addr = '0;
        xif.mem_we = 1'b0; xif.mem_be = '0; xif.mem_wdata = '0;
        xif.result_valid = 1'b0; xif.result_data = '0; xif.result_rd = '0; xif.result_we = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_instr_ready", instr_ready, 0);
        check("rst_issue_valid", xif.issue_valid, 0);
        check("rst_commit_valid", xif.commit_valid, 0);
        check("rst_illegal", illegal, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_data_req", data_req, 0);
        check("rst_mem_result_valid", xif.mem_result_valid, 0);
        rst_i = 1'b0;
        #1;
        check("idle_instr_ready", instr_ready, 1);

        // Accepted instruction with write-back
        send_instr(32'h0000_100B, 32'h1111_0001, 32'h2222_0002);
        check("t1_issue_valid", xif.issue_valid, 1);
        check("t1_issue_instr", xif.issue_instr, 32'h0000_100B);
        check("t1_issue_rs1", xif.issue_rs[0], 32'h1111_0001);
        check("t1_issue_rs2", xif.issue_rs[1], 32'h2222_0002);
        check("t1_rs_valid", xif.issue_rs_valid, 2'b11);
        check("t1_issue_id", xif.issue_id, 0);
        tick();
        check("t1_hold_valid", xif.issue_valid, 1);
        check("t1_hold_instr", xif.issue_instr, 32'h0000_100B);
        issue_hs(1'b1);
        check("t1_commit_valid", xif.commit_valid, 1);
        check("t1_commit_id", xif.commit_id, 0);
        check("t1_commit_kill", xif.commit_kill, 0);
        check("t1_no_illegal", illegal, 0);
        check("t1_busy_ready", instr_ready, 0);
        tick();
        check("t1_commit_once", xif.commit_valid, 0);
        check("t1_ready_again", instr_ready, 1);
        xif.result_valid = 1'b1; xif.result_rd = 5'd5; xif.result_data = 32'hDEAD_BEEF; xif.result_we = 1'b1;
        #1;
        check("t1_result_ready", xif.result_ready, 1);
        tick();
        xif.result_valid = 1'b0; xif.result_we = 1'b0;
        check("t1_rf_we", rf_we, 1);
        check("t1_rf_waddr", rf_waddr, 5);
        check("t1_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        tick();
        check("t1_rf_we_pulse", rf_we, 0);

        // Rejected instruction
        send_instr(32'h0000_200B, 32'h3, 32'h4);
        issue_hs(1'b0);
        check("t2_illegal", illegal, 1);
        check("t2_commit_kill", xif.commit_kill, 1);
        check("t2_commit_id", xif.commit_id, 1);
        tick();
        check("t2_illegal_pulse", illegal, 0);

        // Back-pressure: four accepted, no results (also proves the reject left the count at 0)
        for (int k = 0; k < 4; k++) begin
            send_instr(32'h0000_300B + 32'(k), 32'(k), 32'(k));
            issue_hs(1'b1);
            tick();
        end
        check("bp_full_ready", instr_ready, 0);
        instr_valid = 1'b1; instr_w = 32'h0000_400B;
        tick();
        check("bp_blocked", xif.issue_valid, 0);
        xif.result_valid = 1'b1; xif.result_we = 1'b0;
        tick();
        xif.result_valid = 1'b0;
        check("bp_ready_after_result", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        check("bp_issue_valid", xif.issue_valid, 1);
        check("bp_issue_id", xif.issue_id, 6);
        issue_hs(1'b0);
        tick();

        // Drain three outstanding results back to back
        xif.result_valid = 1'b1; xif.result_we = 1'b1;
        xif.result_rd = 5'd1; xif.result_data = 32'hA0A0_0001;
        tick();
        check("b2b_we1", rf_we, 1);
        check("b2b_addr1", rf_waddr, 1);
        xif.result_rd = 5'd2; xif.result_data = 32'hB0B0_0002;
        tick();
        check("b2b_we2", rf_we, 1);
        check("b2b_data2", rf_wdata, 32'hB0B0_0002);
        xif.result_rd = 5'd31; xif.result_data = 32'hC0C0_0003;
        tick();
        xif.result_valid = 1'b0; xif.result_we = 1'b0;
        check("b2b_addr3", rf_waddr, 31);
        tick();
        check("b2b_we_off", rf_we, 0);

        // Memory read with a delayed grant and a second request stalled behind it
        xif.mem_valid = 1'b1; xif.mem_addr = 32'h0000_0100; xif.mem_id = 4'd3;
        xif.mem_we = 1'b0; xif.mem_be = 4'hF;
        #1;
        check("mem_req", data_req, 1);
        check("mem_addr", data_addr, 32'h0000_0100);
        check("mem_be", data_be, 4'hF);
        check("mem_not_ready", xif.mem_ready, 0);
        tick();
        tick();
        check("mem_req_held", data_req, 1);
        data_gnt = 1'b1;
        #1;
        check("mem_ready_on_gnt", xif.mem_ready, 1);
        tick();
        xif.mem_addr = 32'h0000_0104; xif.mem_id = 4'd4;
        #1;
        check("mem2_stalled_req", data_req, 0);
        check("mem2_stalled_ready", xif.mem_ready, 0);
        tick();
        data_rvalid = 1'b1; data_rdata = 32'h1234_5678;
        #1;
        check("mem_result_valid", xif.mem_result_valid, 1);
        check("mem_result_rdata", xif.mem_result_rdata, 32'h1234_5678);
        check("mem_result_id", xif.mem_result_id, 3);
        check("mem_result_err", xif.mem_result_err, 0);
        check("mem_exc", xif.mem_exc, 0);
        tick();
        data_rvalid = 1'b0;
        #1;
        check("mem_result_once", xif.mem_result_valid, 0);
        check("mem2_req", data_req, 1);
        check("mem2_addr", data_addr, 32'h0000_0104);
        tick();
        data_gnt = 1'b0; xif.mem_valid = 1'b0;

        // Reset mid-ISSUE with a memory transaction still pending
        send_instr(32'h0000_500B, 32'h5, 32'h6);
        check("rst2_in_issue", xif.issue_valid, 1);
        rst_i = 1'b1;
        tick();
        check("rst2_issue_valid", xif.issue_valid, 0);
        check("rst2_issue_id", xif.issue_id, 0);
        check("rst2_issue_instr", xif.issue_instr, 0);
        check("rst2_commit_valid", xif.commit_valid, 0);
        check("rst2_instr_ready", instr_ready, 0);
        check("rst2_illegal", illegal, 0);
        check("rst2_rf_we", rf_we, 0);
        rst_i = 1'b0; data_rvalid = 1'b1; data_rdata = 32'hCAFE_F00D;
        #1;
        check("rst2_late_rvalid", xif.mem_result_valid, 0);
        check("rst2_ready", instr_ready, 1);
        data_rvalid = 1'b0;

        // ID wrap over 17 issues
        for (int i = 0; i < 17; i++) begin
            exp_id = 4'(i % 16);
            send_instr(32'h0000_600B, 32'(i), 32'(i));
            check($sformatf("wrap_issue_id_%0d", i), xif.issue_id, exp_id);
            issue_hs(1'b0);
            check($sformatf("wrap_commit_id_%0d", i), xif.commit_id, exp_id);
            tick();
        end

`ifdef FIR_XIFU_OFFLOAD_KILL_EN
        // Kill before an accepted issue: killed commit, slot returned
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        send_instr(32'h0000_700B, 32'h7, 32'h8);
        issue_hs(1'b1);
        check("kill_commit_kill", xif.commit_kill, 1);
        check("kill_no_illegal", illegal, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            send_instr(32'h0000_800B, 32'(k), 32'(k));
            issue_hs(1'b1);
            check($sformatf("kill_cleared_%0d", k), xif.commit_kill, 0);
            tick();
        end
        check("kill_count_full", instr_ready, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
